// File: rtl/ipv4_pkg.sv
// Shared constants and types for the IPv4 header transmit path.
package ipv4_pkg;

  localparam int IP_VERSION  = 4;
  localparam int IHL         = 5;
  localparam int HDR_WORDS   = 10;
  localparam int HDR_BITS    = 160;
  localparam int MAX_PAYLOAD = 65515;

  localparam logic [7:0] PROTO_UDP = 8'h11;
  localparam logic [7:0] PROTO_TCP = 8'h06;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SEND
  } ipv4_tx_state_t;

endpackage

// File: rtl/ones_comp_acc.sv
// 16-bit one's-complement accumulator with end-around carry folded on
// every add, so the held sum is always a valid 16-bit partial checksum.
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : zero the accumulator (wins over add_valid_i)
//   add_valid_i  : add word_i this cycle
//   word_i       : 16-bit word to add
//   sum_o        : folded running sum
module ones_comp_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        add_valid_i,
  input  logic [15:0] word_i,
  output logic [15:0] sum_o
);

  logic [15:0] acc_q, acc_d;
  logic [16:0] raw_sum;

  // A carry out of 0xFFFF+0xFFFF leaves at most 0xFFFE in the low half,
  // so adding the carry back in can never overflow again.
  always_comb begin
    raw_sum = {1'b0, acc_q} + {1'b0, word_i};
    acc_d   = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_valid_i) begin
      acc_d = raw_sum[15:0] + {15'b0, raw_sum[16]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign sum_o = acc_q;

endmodule

// File: rtl/ipv4_header_tx.sv
// IPv4 header serializer. Accepts one header request, sums the header
// words into a checksum, then streams the 20-byte header MSB-first,
// N bits per beat, with backpressure and abort.
//   start_valid/start_ready        : request handshake
//   payload_len/src_ip/dst_ip/protocol : request fields, latched on accept
//   abort                          : flush current header (CALC/SEND)
//   axiov/axiod/axi_ready/axi_last : output beat stream
//   len_err                        : one-cycle pulse on oversize request
//   busy                           : not IDLE
//
// state | meaning
// IDLE  | waiting for a request, start_ready high
// CALC  | cnt 0..8 add one header word each; cnt 9 hands off to SEND
// SEND  | cnt is the beat index; advances on axi_ready
module ipv4_header_tx
  import ipv4_pkg::*;
#(
  parameter int          N       = 2,
  parameter logic [7:0]  TTL     = 8'd64,
  parameter logic [5:0]  DSCP    = 6'd0,
  parameter logic        DF      = 1'b1,
  parameter logic [15:0] ID_INIT = 16'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [15:0]   payload_len,
  input  logic [31:0]   src_ip,
  input  logic [31:0]   dst_ip,
  input  logic [7:0]    protocol,
  input  logic          abort,
  output logic          axiov,
  output logic [N-1:0]  axiod,
  input  logic          axi_ready,
  output logic          axi_last,
  output logic          len_err,
  output logic          busy
);

  localparam logic [7:0] LAST_BEAT = 8'(HDR_BITS / N - 1);
  localparam logic [7:0] LAST_CALC = 8'd9;

  ipv4_tx_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] id_q, id_d;
  logic        len_err_q, len_err_d;
  logic [15:0] plen_q;
  logic [31:0] src_q, dst_q;
  logic [7:0]  proto_q;

  logic        accept, len_ok;
  logic        acc_clear, acc_add;
  logic [15:0] acc_word, acc_sum;
  logic [0:HDR_WORDS-1][15:0] w;
  logic [HDR_BITS-1:0] hdr_sh;

  assign accept = start_valid && (state_q == IDLE);
  assign len_ok = payload_len <= 16'(MAX_PAYLOAD);

  // The accumulator is left untouched during SEND, so its inverse is the
  // checksum for the whole header without a separate register.
  always_comb begin
    w    = '0;
    w[0] = {4'(IP_VERSION), 4'(IHL), DSCP, 2'b00};
    w[1] = plen_q + 16'd20;
    w[2] = id_q;
    w[3] = {1'b0, DF, 14'b0};
    w[4] = {TTL, proto_q};
    w[5] = ~acc_sum;
    w[6] = src_q[31:16];
    w[7] = src_q[15:0];
    w[8] = dst_q[31:16];
    w[9] = dst_q[15:0];
  end

  // Checksum word itself is skipped during the sum.
  always_comb begin
    acc_word = w[0];
    case (cnt_q[3:0])
      4'd1:    acc_word = w[1];
      4'd2:    acc_word = w[2];
      4'd3:    acc_word = w[3];
      4'd4:    acc_word = w[4];
      4'd5:    acc_word = w[6];
      4'd6:    acc_word = w[7];
      4'd7:    acc_word = w[8];
      4'd8:    acc_word = w[9];
      default: acc_word = w[0];
    endcase
  end

  assign acc_clear = accept && len_ok;
  assign acc_add   = (state_q == CALC) && (cnt_q != LAST_CALC);

  ones_comp_acc u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (acc_clear),
    .add_valid_i (acc_add),
    .word_i      (acc_word),
    .sum_o       (acc_sum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    len_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (len_ok) begin
            state_d = CALC;
            cnt_d   = '0;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CALC) begin
          state_d = SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (axi_ready) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            id_d    = id_q + 16'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      id_q      <= ID_INIT;
      len_err_q <= 1'b0;
      plen_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      proto_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      len_err_q <= len_err_d;
      if (accept) begin
        plen_q  <= payload_len;
        src_q   <= src_ip;
        dst_q   <= dst_ip;
        proto_q <= protocol;
      end
    end
  end

  // Beat selection depends only on registered state and count.
  assign hdr_sh      = w << (32'(cnt_q) * N);
  assign axiov       = (state_q == SEND);
  assign axiod       = axiov ? hdr_sh[HDR_BITS-1 -: N] : '0;
  assign axi_last    = axiov && (cnt_q == LAST_BEAT);
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_ipv4_header_tx.sv
module tb_ipv4_header_tx;
  import ipv4_pkg::*;

  logic clk;
  logic rst_n;
  logic [2:0] sv, ar, sr, ov, ol, le, bz;
  logic [15:0] payload_len;
  logic [31:0] src_ip, dst_ip;
  logic [7:0]  protocol;
  logic        abort;
  logic [1:0]  d2;
  logic [7:0]  d8;
  logic [0:0]  d1;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] id_m [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ipv4_header_tx #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
    .payload_len(payload_len), .src_ip(src_ip), .dst_ip(dst_ip), .protocol(protocol),
    .abort(abort), .axiov(ov[0]), .axiod(d2), .axi_ready(ar[0]), .axi_last(ol[0]),
    .len_err(le[0]), .busy(bz[0]));

  ipv4_header_tx #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
    .payload_len(payload_len), .src_ip(src_ip), .dst_ip(dst_ip), .protocol(protocol),
    .abort(abort), .axiov(ov[1]), .axiod(d8), .axi_ready(ar[1]), .axi_last(ol[1]),
    .len_err(le[1]), .busy(bz[1]));

  ipv4_header_tx #(.N(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr[2]),
    .payload_len(payload_len), .src_ip(src_ip), .dst_ip(dst_ip), .protocol(protocol),
    .abort(abort), .axiov(ov[2]), .axiod(d1), .axi_ready(ar[2]), .axi_last(ol[2]),
    .len_err(le[2]), .busy(bz[2]));

  function automatic int nbits(input int i);
    case (i)
      0:       return 2;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] get_d(input int i);
    case (i)
      0:       return {6'b0, d2};
      1:       return d8;
      default: return {7'b0, d1};
    endcase
  endfunction

  // Reference header: total sum then fold, TTL=64, DSCP=0, DF=1.
  function automatic logic [159:0] model(input logic [15:0] plen, input logic [31:0] s,
                                         input logic [31:0] d, input logic [7:0] pr,
                                         input logic [15:0] id);
    int unsigned wv [10];
    int unsigned sum;
    logic [159:0] r;
    wv[0] = 32'h4500;
    wv[1] = (32'(plen) + 32'd20) & 32'hFFFF;
    wv[2] = 32'(id);
    wv[3] = 32'h4000;
    wv[4] = (32'd64 << 8) | 32'(pr);
    wv[5] = 0;
    wv[6] = s >> 16;
    wv[7] = s & 32'hFFFF;
    wv[8] = d >> 16;
    wv[9] = d & 32'hFFFF;
    sum = 0;
    for (int j = 0; j < 10; j++) sum += wv[j];
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    wv[5] = (~sum) & 32'hFFFF;
    r = '0;
    for (int j = 0; j < 10; j++) r = (r << 16) | 160'(wv[j]);
    return r;
  endfunction

  // Issues one request on instance i and collects the full header.
  task automatic run_hdr(input int i, input bit rnd, input logic [15:0] plen,
                         input logic [31:0] s, input logic [31:0] dd, input logic [7:0] pr,
                         input logic [159:0] exp, input string nm);
    int n, beats, lat, k, cyc, bad_last, bad_hold, bad_v, sr_hi;
    bit stall;
    logic [7:0] pd, cd;
    logic [159:0] got;
    n = nbits(i); beats = 160 / n; got = '0;
    bad_last = 0; bad_hold = 0; bad_v = 0; sr_hi = 0;
    payload_len = plen; src_ip = s; dst_ip = dd; protocol = pr;
    sv[i] = 1'b1; ar[i] = 1'b1;
    n_chk++;
    if (sr[i] !== 1'b1) begin n_fail++; $display("FAIL %s start_ready_idle: got %b want 1", nm, sr[i]); end
    @(negedge clk);
    sv[i] = 1'b0;
    lat = 0;
    while (ov[i] !== 1'b1 && lat < 40) begin
      if (sr[i] !== 1'b0) sr_hi++;
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat != 10) begin n_fail++; $display("FAIL %s first_valid_latency: got %0d want 10", nm, lat); end
    k = 0; cyc = 0; stall = 0; pd = '0;
    while (k < beats && cyc < 4000) begin
      cd = get_d(i);
      if (ov[i] !== 1'b1) bad_v++;
      if (stall && cd !== pd) bad_hold++;
      if (ol[i] !== 1'(k == beats - 1)) bad_last++;
      if (sr[i] !== 1'b0) sr_hi++;
      ar[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ar[i]) begin
        got = (got << n) | 160'(cd);
        k++;
      end
      stall = !ar[i];
      pd = cd;
      @(negedge clk);
      cyc++;
    end
    ar[i] = 1'b1;
    n_chk++;
    if (k != beats) begin n_fail++; $display("FAIL %s beat_count: got %0d want %0d", nm, k, beats); end
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL %s header: got %h want %h", nm, got, exp); end
    n_chk++;
    if (bad_last != 0) begin n_fail++; $display("FAIL %s axi_last_position: got %0d bad beats want 0", nm, bad_last); end
    n_chk++;
    if (bad_v != 0) begin n_fail++; $display("FAIL %s axiov_gap: got %0d drops want 0", nm, bad_v); end
    n_chk++;
    if (bad_hold != 0) begin n_fail++; $display("FAIL %s stall_hold: got %0d changes want 0", nm, bad_hold); end
    n_chk++;
    if (sr_hi != 0) begin n_fail++; $display("FAIL %s start_ready_busy: got %0d high cycles want 0", nm, sr_hi); end
    n_chk++;
    if (ov[i] !== 1'b0 || sr[i] !== 1'b1) begin
      n_fail++; $display("FAIL %s after_last: got axiov=%b start_ready=%b want 0/1", nm, ov[i], sr[i]);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (sr[i] !== 1'b1 || ov[i] !== 1'b0 || ol[i] !== 1'b0 || le[i] !== 1'b0 ||
          bz[i] !== 1'b0 || get_d(i) !== 8'h00) begin
        n_fail++;
        $display("FAIL %s inst%0d: got sr=%b v=%b last=%b lerr=%b busy=%b d=%h want 1/0/0/0/0/00",
                 nm, i, sr[i], ov[i], ol[i], le[i], bz[i], get_d(i));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sv = '0; ar = '1; abort = 1'b0;
    payload_len = '0; src_ip = '0; dst_ip = '0; protocol = '0;
    for (int i = 0; i < 3; i++) id_m[i] = 16'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_basic();
    run_hdr(0, 1'b0, 16'h005F, 32'hC0A80001, 32'hC0A800C7, PROTO_UDP,
            160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7, "basic_n2");
    id_m[0]++;
  endtask

  task automatic test_back_to_back();
    run_hdr(0, 1'b0, 16'h005F, 32'hC0A80001, 32'hC0A800C7, PROTO_UDP,
            160'h4500_0073_0001_4000_4011_B860_C0A8_0001_C0A8_00C7, "back_to_back");
    id_m[0]++;
  endtask

  task automatic test_random_ready();
    logic [15:0] pl;
    logic [31:0] s, d;
    logic [7:0] pr;
    run_hdr(1, 1'b1, 16'h005F, 32'hC0A80001, 32'hC0A800C7, PROTO_UDP,
            160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7, "stall_n8");
    id_m[1]++;
    for (int t = 0; t < 4; t++) begin
      pl = 16'($urandom_range(0, MAX_PAYLOAD));
      s = $urandom; d = $urandom;
      pr = ($urandom_range(0, 1) == 1) ? PROTO_TCP : PROTO_UDP;
      run_hdr(1, 1'b1, pl, s, d, pr, model(pl, s, d, pr, id_m[1]), "rand_n8");
      id_m[1]++;
    end
  endtask

  task automatic test_len_err();
    int le_cnt, v_cnt, sr_lo;
    payload_len = 16'hFFEC; src_ip = 32'h0A000001; dst_ip = 32'h0A000002; protocol = PROTO_UDP;
    sv[2] = 1'b1;
    @(negedge clk);
    sv[2] = 1'b0;
    n_chk++;
    if (le[2] !== 1'b1) begin n_fail++; $display("FAIL len_err_pulse: got %b want 1", le[2]); end
    le_cnt = 0; v_cnt = 0; sr_lo = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (le[2] === 1'b1) le_cnt++;
      if (ov[2] === 1'b1) v_cnt++;
      if (sr[2] !== 1'b1) sr_lo++;
    end
    n_chk++;
    if (le_cnt != 0) begin n_fail++; $display("FAIL len_err_single: got %0d extra pulses want 0", le_cnt); end
    n_chk++;
    if (v_cnt != 0 || sr_lo != 0) begin
      n_fail++; $display("FAIL len_err_no_output: got %0d valid / %0d busy cycles want 0/0", v_cnt, sr_lo);
    end
    run_hdr(2, 1'b0, 16'd65515, 32'h0A000001, 32'h0A000002, PROTO_UDP,
            model(16'd65515, 32'h0A000001, 32'h0A000002, PROTO_UDP, id_m[2]), "len_max_ok");
    id_m[2]++;
  endtask

  task automatic test_abort();
    int lat, last_seen;
    payload_len = 16'h0040; src_ip = 32'h01020304; dst_ip = 32'h05060708; protocol = PROTO_TCP;
    sv[0] = 1'b1; ar[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0;
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    last_seen = 0;
    for (int b = 0; b < 30; b++) begin
      if (ol[0] === 1'b1) last_seen++;
      @(negedge clk);
    end
    n_chk++;
    if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL abort_pre_valid: got %b want 1", ov[0]); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    if (ol[0] === 1'b1) last_seen++;
    n_chk++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || sr[0] !== 1'b1) begin
      n_fail++; $display("FAIL abort_flush: got v=%b busy=%b sr=%b want 0/0/1", ov[0], bz[0], sr[0]);
    end
    n_chk++;
    if (last_seen != 0) begin n_fail++; $display("FAIL abort_no_last: got %0d want 0", last_seen); end
    run_hdr(0, 1'b0, 16'h0200, 32'hAC100001, 32'hAC1000FE, PROTO_UDP,
            model(16'h0200, 32'hAC100001, 32'hAC1000FE, PROTO_UDP, id_m[0]), "after_abort");
    id_m[0]++;
  endtask

  task automatic test_reset_mid();
    int lat;
    payload_len = 16'h0100; src_ip = 32'hDEADBEEF; dst_ip = 32'h12345678; protocol = PROTO_UDP;
    sv[2] = 1'b1; ar[2] = 1'b1;
    @(negedge clk);
    sv[2] = 1'b0;
    lat = 0;
    while (ov[2] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ov[2] !== 1'b0 || ol[2] !== 1'b0 || d1 !== 1'b0 || bz[2] !== 1'b0 || le[2] !== 1'b0 || sr[2] !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_mid: got v=%b last=%b d=%b busy=%b lerr=%b sr=%b want 0/0/0/0/0/1",
                         ov[2], ol[2], d1, bz[2], le[2], sr[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) id_m[i] = 16'd0;
    @(negedge clk);
    run_hdr(2, 1'b0, 16'h0100, 32'hDEADBEEF, 32'h12345678, PROTO_UDP,
            model(16'h0100, 32'hDEADBEEF, 32'h12345678, PROTO_UDP, id_m[2]), "after_reset_n1");
    id_m[2]++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random_ready();
    test_len_err();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
